// File: rtl/fft_row_pass_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_row_pass_ctrl_if
// Bundles the filter-buffer input, the FFT core AXI-Stream input/output,
// the ROI bank write port and the status flags of the row-pass controller.
//
// Parameters : DW (sample width), RW (result width), BANK_LOG2 (log2 bank
//              count), BAW (bank address width).
// Modports   : master - the row-pass controller side
//              slave  - the surrounding environment (filter buffer, FFT
//                       core, ROI banks, frame sequencer)
// Signals    : frame_start, filbuf_wren, filbuf_wrdata      (env -> ctrl)
//              fft_data_ready/valid/last/data               (input stream)
//              fft_result_ready/valid/last/data             (result stream)
//              bank_wren, bank_wraddr, bank_wrdata          (ctrl -> banks)
//              fft_2ndR_config, busy, in_overflow, last_err (status)
// ---------------------------------------------------------------------------
interface fft_row_pass_ctrl_if #(
    parameter int unsigned DW        = 32,
    parameter int unsigned RW        = 64,
    parameter int unsigned BANK_LOG2 = 2,
    parameter int unsigned BAW       = 12
);
    localparam int unsigned NBANK = 1 << BANK_LOG2;

    logic             frame_start;
    logic             filbuf_wren;
    logic [DW-1:0]    filbuf_wrdata;

    logic             fft_data_ready;
    logic             fft_data_valid;
    logic             fft_data_last;
    logic [63:0]      fft_data_data;

    logic             fft_result_ready;
    logic             fft_result_valid;
    logic             fft_result_last;
    logic [RW-1:0]    fft_result_data;

    logic [NBANK-1:0] bank_wren;
    logic [BAW-1:0]   bank_wraddr;
    logic [RW-1:0]    bank_wrdata;

    logic             fft_2ndR_config;
    logic             busy;
    logic             in_overflow;
    logic             last_err;

    modport master (
        input  frame_start, filbuf_wren, filbuf_wrdata,
        input  fft_data_ready,
        output fft_data_valid, fft_data_last, fft_data_data,
        output fft_result_ready,
        input  fft_result_valid, fft_result_last, fft_result_data,
        output bank_wren, bank_wraddr, bank_wrdata,
        output fft_2ndR_config, busy, in_overflow, last_err
    );

    modport slave (
        output frame_start, filbuf_wren, filbuf_wrdata,
        output fft_data_ready,
        input  fft_data_valid, fft_data_last, fft_data_data,
        input  fft_result_ready,
        output fft_result_valid, fft_result_last, fft_result_data,
        input  bank_wren, bank_wraddr, bank_wrdata,
        input  fft_2ndR_config, busy, in_overflow, last_err
    );
endinterface

// File: rtl/fft_row_pass_ctrl.sv
// ---------------------------------------------------------------------------
// fft_row_pass_ctrl
// Row-pass controller for the 2-D FFT path. Filtered samples are buffered in
// a first-word-fall-through FIFO and streamed into the FFT core with an
// internally generated tlast per row. FFT results are written into NBANK ROI
// banks in row-major or column-major order; a one-cycle strobe marks the
// write of the last beat of a frame.
//
// Ports:
//   s_axi_aclk    - sole clock, rising edge
//   s_axi_aresetn - asynchronous active-low reset
//   bus           - fft_row_pass_ctrl_if master modport (stream, bank and
//                   status signals)
// ---------------------------------------------------------------------------
module fft_row_pass_ctrl #(
    parameter int unsigned NFFT_LOG2 = 7,
    parameter int unsigned NROW_LOG2 = 7,
    parameter int unsigned BANK_LOG2 = 2,
    parameter int unsigned DW        = 32,
    parameter int unsigned RW        = 64,
    parameter int unsigned FIFO_LOG2 = 4,
    parameter int unsigned TRANSPOSE = 0
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    fft_row_pass_ctrl_if.master bus
);
    localparam int unsigned AW    = NFFT_LOG2 + NROW_LOG2;
    localparam int unsigned BAW   = AW - BANK_LOG2;
    localparam int unsigned NBANK = 1 << BANK_LOG2;
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CW    = FIFO_LOG2 + 1;

    localparam logic [NFFT_LOG2-1:0] COL_LAST = '1;
    localparam logic [NROW_LOG2-1:0] ROW_LAST = '1;
    localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);

    // FIFO storage and pointers
    logic [DW-1:0]        mem [DEPTH];
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [CW-1:0]        count;

    // stream / result position counters
    logic [NFFT_LOG2-1:0] icol;
    logic [NFFT_LOG2-1:0] rcol;
    logic [NROW_LOG2-1:0] rrow;

    // registered outputs
    logic [NBANK-1:0]     bank_wren_q;
    logic [BAW-1:0]       bank_wraddr_q;
    logic [RW-1:0]        bank_wrdata_q;
    logic                 config_q;
    logic                 busy_q;
    logic                 overflow_q;
    logic                 last_err_q;

    logic                 empty_c;
    logic                 full_c;
    logic                 pop_c;
    logic                 push_c;
    logic                 col_end_c;
    logic                 frame_end_c;
    logic [AW-1:0]        addr_c;

    // FIFO status and handshake qualification
    assign empty_c = (count == '0);
    assign full_c  = (count == FULL_CNT);
    assign pop_c   = !empty_c && bus.fft_data_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_c  = bus.filbuf_wren && (!full_c || pop_c);

    // result position decode
    assign col_end_c   = (rcol == COL_LAST);
    assign frame_end_c = col_end_c && (rrow == ROW_LAST);

    // frame address in linear or transposed order
    always_comb begin
        addr_c = {rrow, rcol};
        if (TRANSPOSE != 0) begin
            addr_c = {rcol, rrow};
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility
    always_ff @(posedge s_axi_aclk) begin
        if (bus.frame_start) begin
            if (bus.filbuf_wren) begin
                mem[0] <= bus.filbuf_wrdata;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= bus.filbuf_wrdata;
        end
    end

    // control state: FIFO pointers, counters, bank write port and flags
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            icol          <= '0;
            rcol          <= '0;
            rrow          <= '0;
            bank_wren_q   <= '0;
            bank_wraddr_q <= '0;
            bank_wrdata_q <= '0;
            config_q      <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            last_err_q    <= 1'b0;
        end else if (bus.frame_start) begin
            // clear everything; a coincident sample becomes sample 0
            rd_ptr      <= '0;
            wr_ptr      <= FIFO_LOG2'(bus.filbuf_wren);
            count       <= CW'(bus.filbuf_wren);
            icol        <= '0;
            rcol        <= '0;
            rrow        <= '0;
            bank_wren_q <= '0;
            config_q    <= 1'b0;
            busy_q      <= bus.filbuf_wren;
            overflow_q  <= 1'b0;
            last_err_q  <= 1'b0;
        end else begin
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_LOG2'(1);
                icol   <= icol + NFFT_LOG2'(1);
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (bus.filbuf_wren && !push_c) begin
                overflow_q <= 1'b1;
            end

            bank_wren_q <= '0;
            config_q    <= 1'b0;
            if (bus.fft_result_valid) begin
                bank_wren_q   <= NBANK'(1) << (addr_c >> BAW);
                bank_wraddr_q <= BAW'(addr_c);
                bank_wrdata_q <= bus.fft_result_data;
                config_q      <= frame_end_c;
                if (bus.fft_result_last != col_end_c) begin
                    last_err_q <= 1'b1;
                end
                // tlast forces a row break even when it arrives early
                if (bus.fft_result_last || col_end_c) begin
                    rcol <= '0;
                    rrow <= rrow + NROW_LOG2'(1);
                end else begin
                    rcol <= rcol + NFFT_LOG2'(1);
                end
            end

            // a sample arriving with the frame-end beat opens the next frame
            if (push_c) begin
                busy_q <= 1'b1;
            end else if (bus.fft_result_valid && frame_end_c) begin
                busy_q <= 1'b0;
            end
        end
    end

    // stream outputs follow the registered FIFO state; data reads 0 when empty
    assign bus.fft_data_valid   = !empty_c;
    assign bus.fft_data_last    = !empty_c && (icol == COL_LAST);
    assign bus.fft_data_data    = empty_c ? 64'd0
                                          : {32'd0, 32'($signed(mem[rd_ptr]))};
    assign bus.fft_result_ready = 1'b1;

    assign bus.bank_wren        = bank_wren_q;
    assign bus.bank_wraddr      = bank_wraddr_q;
    assign bus.bank_wrdata      = bank_wrdata_q;
    assign bus.fft_2ndR_config  = config_q;
    assign bus.busy             = busy_q;
    assign bus.in_overflow      = overflow_q;
    assign bus.last_err         = last_err_q;
endmodule

// File: tb/tb_fft_row_pass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_row_pass_ctrl
// Drives a row-major and a column-major instance with identical stimulus and
// compares every output each cycle against a queue/arithmetic reference.
// ---------------------------------------------------------------------------
module tb_fft_row_pass_ctrl;
    localparam int unsigned NFFT_LOG2 = 3;
    localparam int unsigned NROW_LOG2 = 2;
    localparam int unsigned BANK_LOG2 = 1;
    localparam int unsigned FIFO_LOG2 = 2;
    localparam int unsigned DW        = 16;
    localparam int unsigned RW        = 64;
    localparam int unsigned BAW       = NFFT_LOG2 + NROW_LOG2 - BANK_LOG2;
    localparam int          NFFT      = 8;
    localparam int          NROW      = 4;
    localparam int          BANK_SIZE = 16;
    localparam int          DEPTH     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // shared stimulus
    logic          fs, wr, rdy, rv, rl;
    logic [DW-1:0] wd;
    logic [RW-1:0] rd;

    fft_row_pass_ctrl_if #(.DW(DW), .RW(RW), .BANK_LOG2(BANK_LOG2), .BAW(BAW)) b0 ();
    fft_row_pass_ctrl_if #(.DW(DW), .RW(RW), .BANK_LOG2(BANK_LOG2), .BAW(BAW)) b1 ();

    assign b0.frame_start = fs;  assign b1.frame_start = fs;
    assign b0.filbuf_wren = wr;  assign b1.filbuf_wren = wr;
    assign b0.filbuf_wrdata = wd; assign b1.filbuf_wrdata = wd;
    assign b0.fft_data_ready = rdy; assign b1.fft_data_ready = rdy;
    assign b0.fft_result_valid = rv; assign b1.fft_result_valid = rv;
    assign b0.fft_result_last = rl;  assign b1.fft_result_last = rl;
    assign b0.fft_result_data = rd;  assign b1.fft_result_data = rd;

    fft_row_pass_ctrl #(.NFFT_LOG2(NFFT_LOG2), .NROW_LOG2(NROW_LOG2), .BANK_LOG2(BANK_LOG2),
                        .DW(DW), .RW(RW), .FIFO_LOG2(FIFO_LOG2), .TRANSPOSE(0))
        dut0 (.s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(b0.master));
    fft_row_pass_ctrl #(.NFFT_LOG2(NFFT_LOG2), .NROW_LOG2(NROW_LOG2), .BANK_LOG2(BANK_LOG2),
                        .DW(DW), .RW(RW), .FIFO_LOG2(FIFO_LOG2), .TRANSPOSE(1))
        dut1 (.s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(b1.master));

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [DW-1:0] q[$];
    int            pops, row, col;
    bit            m_ovf, m_lerr, m_busy, m_cfg;
    logic [1:0]    m_wren0, m_wren1;
    logic [3:0]    m_addr0, m_addr1;
    logic [63:0]   m_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        e_valid, e_last;
        logic [63:0] e_data;
        int          v;
        e_valid = (q.size() > 0);
        e_last  = e_valid && ((pops % NFFT) == NFFT - 1);
        e_data  = 64'd0;
        if (e_valid) begin
            v = $signed(q[0]);
            e_data = {32'd0, v};
        end
        check("t0_valid", 64'(b0.fft_data_valid), 64'(e_valid));
        check("t0_last",  64'(b0.fft_data_last),  64'(e_last));
        check("t0_data",  b0.fft_data_data,       e_data);
        check("t0_rready", 64'(b0.fft_result_ready), 64'd1);
        check("t0_wren",  64'(b0.bank_wren),      64'(m_wren0));
        check("t0_wraddr", 64'(b0.bank_wraddr),   64'(m_addr0));
        check("t0_wrdata", b0.bank_wrdata,        m_wdata);
        check("t0_cfg",   64'(b0.fft_2ndR_config), 64'(m_cfg));
        check("t0_busy",  64'(b0.busy),           64'(m_busy));
        check("t0_ovf",   64'(b0.in_overflow),    64'(m_ovf));
        check("t0_lerr",  64'(b0.last_err),       64'(m_lerr));
        check("t1_valid", 64'(b1.fft_data_valid), 64'(e_valid));
        check("t1_last",  64'(b1.fft_data_last),  64'(e_last));
        check("t1_data",  b1.fft_data_data,       e_data);
        check("t1_wren",  64'(b1.bank_wren),      64'(m_wren1));
        check("t1_wraddr", 64'(b1.bank_wraddr),   64'(m_addr1));
        check("t1_wrdata", b1.bank_wrdata,        m_wdata);
        check("t1_cfg",   64'(b1.fft_2ndR_config), 64'(m_cfg));
        check("t1_busy",  64'(b1.busy),           64'(m_busy));
        check("t1_ovf",   64'(b1.in_overflow),    64'(m_ovf));
        check("t1_lerr",  64'(b1.last_err),       64'(m_lerr));
    endtask

    task automatic model_reset();
        q.delete();
        pops = 0; row = 0; col = 0;
        m_ovf = 0; m_lerr = 0; m_busy = 0; m_cfg = 0;
        m_wren0 = 0; m_wren1 = 0; m_addr0 = 0; m_addr1 = 0; m_wdata = 0;
    endtask

    // one clock of reference behaviour for the currently driven inputs
    task automatic model_step();
        bit pop, acc;
        int a0, a1;
        if (fs) begin
            q.delete();
            pops = 0; row = 0; col = 0;
            m_ovf = 0; m_lerr = 0; m_busy = 0; m_cfg = 0;
            m_wren0 = 0; m_wren1 = 0;
            if (wr) begin
                q.push_back(wd);
                m_busy = 1;
            end
            return;
        end
        pop = (q.size() > 0) && rdy;
        acc = wr && ((q.size() < DEPTH) || pop);
        if (pop) begin
            void'(q.pop_front());
            pops++;
        end
        if (acc) q.push_back(wd);
        else if (wr) m_ovf = 1;
        m_wren0 = 0; m_wren1 = 0; m_cfg = 0;
        if (rv) begin
            a0 = row * NFFT + col;
            a1 = col * NROW + row;
            m_wren0 = 2'(1 << (a0 / BANK_SIZE));
            m_wren1 = 2'(1 << (a1 / BANK_SIZE));
            m_addr0 = 4'(a0 % BANK_SIZE);
            m_addr1 = 4'(a1 % BANK_SIZE);
            m_wdata = rd;
            if (rl != (col == NFFT - 1)) m_lerr = 1;
            if (row == NROW - 1 && col == NFFT - 1) begin
                m_cfg = 1;
                m_busy = 0;
            end
            if (rl || col == NFFT - 1) begin
                col = 0;
                row = (row + 1) % NROW;
            end else begin
                col++;
            end
        end
        if (acc) m_busy = 1;
    endtask

    task automatic cycle(input bit f, input bit w, input logic [DW-1:0] d, input bit r,
                         input bit v, input bit l, input logic [RW-1:0] x);
        fs = f; wr = w; wd = d; rdy = r; rv = v; rl = l; rd = x;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, r, 0, 0, '0);
    endtask

    // result beat carrying the correct tlast for the current position
    task automatic beat();
        cycle(0, 0, '0, 1, 1, (col == NFFT - 1), {$urandom, $urandom});
    endtask

    initial begin
        rst_n = 1'b0;
        fs = 0; wr = 0; wd = '0; rdy = 0; rv = 0; rl = 0; rd = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // streaming at full rate: 0..31, tlast every 8th
        for (int i = 0; i < 32; i++) cycle(0, 1, DW'(i), 1, 0, 0, '0);
        idle(1, 3);

        // backpressure: four held, fifth dropped, then drain
        for (int i = 0; i < 5; i++) cycle(0, 1, DW'(i), 0, 0, 0, '0);
        idle(0, 2);
        idle(1, 6);

        // negative samples exercise sign extension
        cycle(0, 1, 16'h8001, 1, 0, 0, '0);
        cycle(0, 1, 16'hFFFF, 1, 0, 0, '0);
        idle(1, 3);

        // full frame of results in both address orders
        cycle(1, 0, '0, 1, 0, 0, '0);
        for (int i = 0; i < 32; i++) beat();
        idle(1, 3);

        // early tlast at column 3
        for (int i = 0; i < 3; i++) beat();
        cycle(0, 0, '0, 1, 1, 1, 64'h1234);
        beat();
        idle(1, 2);

        // mid-frame clear with coincident sample and result beat
        for (int i = 0; i < 5; i++) cycle(0, 1, DW'(i + 40), 0, 0, 0, '0);
        beat();
        cycle(1, 1, DW'(9), 1, 1, 0, 64'hDEAD);
        idle(0, 2);
        beat();
        idle(1, 2);

        // asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) cycle(0, 1, DW'(i + 60), 0, 1, 0, 64'(i + 7));
        rst_n = 1'b0;
        fs = 0; wr = 0; rdy = 0; rv = 0; rl = 0;
        model_reset();
        #2;
        check_all();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit f, w, r, v, l;
            f = ($urandom_range(0, 79) == 0);
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 1) == 1);
            l = (col == NFFT - 1);
            if ($urandom_range(0, 15) == 0) l = !l;
            cycle(f, w, DW'($urandom), r, v, l, {$urandom, $urandom});
        end
        idle(1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_row_pass_ctrl.md
# fft_row_pass_ctrl

Parametrised row-pass controller for the 2-D FFT path. It streams filtered pixels from the filter-buffer write port into the Xilinx FFT core's AXI-Stream input through a backpressure FIFO, with tlast generated internally. It collects FFT results into NBANK ROI BRAM banks, in linear or transposed order, and pulses the second-pass configuration strobe when a full frame has been written. Successor to the fixed 128×128, 4-bank, no-backpressure row controller.

## Interface
- NFFT_LOG2, 7: log2 of FFT points per row (row length).
- NROW_LOG2, 7: log2 of rows per frame.
- BANK_LOG2, 2: log2 of BRAM bank count (NBANK = 2^BANK_LOG2).
- DW, 32: input sample width, ≤ 32, signed.
- RW, 64: FFT result / bank data width.
- FIFO_LOG2, 4: log2 of input FIFO depth.
- TRANSPOSE, 0: 0 = row-major bank addressing; 1 = column-major.

Derived widths: AW = NFFT_LOG2 + NROW_LOG2 (frame address); BAW = AW − BANK_LOG2 (bank address).

- s_axi_aclk  in  1  sole clock, rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- frame_start  in  1  synchronous one-cycle clear of the FIFO, counters and flags.
- filbuf_wren  in  1  sample strobe.
- filbuf_wrdata  in  DW  sample (real part).
- fft_data_ready  in  1  FFT core tready.
- fft_data_valid  out  1  tvalid.
- fft_data_last  out  1  tlast, marks the last sample of each row.
- fft_data_data  out  64  [31:0] = sign-extended sample, [63:32] = 0.
- fft_result_ready  out  1  constant 1.
- fft_result_valid  in  1  result tvalid.
- fft_result_last  in  1  result tlast.
- fft_result_data  in  RW  result.
- bank_wren  out  NBANK  one-hot bank write enable.
- bank_wraddr  out  BAW  shared bank address.
- bank_wrdata  out  RW  shared bank data.
- fft_2ndR_config  out  1  one-cycle end-of-frame pulse.
- busy  out  1  frame in progress.
- in_overflow  out  1  sticky: sample dropped because the FIFO was full.
- last_err  out  1  sticky: result tlast did not match the expected position.

## Operation
- **Input FIFO** (first-word-fall-through, depth 2^FIFO_LOG2).
  - A push occurs on filbuf_wren.
  - fft_data_valid = !empty; a pop occurs on valid && ready.
  - Push and pop in the same cycle are both honoured when the FIFO is full; the count is unchanged.
  - A push while full and not popping drops the sample and sets in_overflow.
- **Input counter** `icol` (NFFT_LOG2 bits) advances on each pop and wraps.
  - fft_data_last = valid && (icol == NFFT−1), driven combinationally from the registered count.
  - filbuf write addresses are not used.
- **Result counters** `rcol` (NFFT_LOG2 bits) and `rrow` (NROW_LOG2 bits) advance on each result beat (fft_result_valid).
  - rcol wraps to 0 at NFFT−1 and rrow increments at that point.
  - If fft_result_last = 1, the next beat always starts at rcol = 0, rrow + 1, regardless of rcol.
  - last_err is set when fft_result_last != (rcol == NFFT−1).
- **Address mapping.**
  - TRANSPOSE = 0: addr = {rrow, rcol}.
  - TRANSPOSE = 1: addr = {rcol, rrow}.
  - The bank index is addr[AW−1 : BAW]; bank_wraddr = addr[BAW−1 : 0].
- **Frame end.** When the beat at rrow = NROW−1, rcol = NFFT−1 is written:
  - fft_2ndR_config pulses in the same cycle as that bank write;
  - the counters wrap to 0;
  - busy falls.
- **busy** rises on the first accepted push after reset, frame_start, or frame end.
- **frame_start** clears the FIFO, icol, rcol, rrow, busy, in_overflow and last_err.
  - A filbuf_wren in the same cycle is pushed into the cleared FIFO as sample 0 and sets busy.
  - A result beat in the same cycle is discarded: no bank write, no flag update.
- **Reset** (asynchronous, mid-frame included) has the same effect as frame_start, with no sample accepted.

## Timing
- **Reset values:**
  - fft_data_valid 0, fft_data_last 0, fft_data_data 0;
  - bank_wren 0, bank_wraddr 0, bank_wrdata 0;
  - fft_2ndR_config 0, busy 0, in_overflow 0, last_err 0;
  - fft_result_ready 1.
- **Input latency:** a sample pushed into an empty FIFO in cycle t presents on fft_data_valid in cycle t+1. Sustained throughput is 1 sample/cycle.
- **Result latency:** a beat in cycle t produces bank_wren/addr/data registered in t+1, and fft_2ndR_config in t+1.
- **Hold under backpressure:** fft_data_data and fft_data_last are stable while valid && !ready.
- **Flag timing:** in_overflow and last_err assert in the cycle after the offending event.

## Test plan
Parameters for all scenarios: NFFT_LOG2 = 3, NROW_LOG2 = 2, BANK_LOG2 = 1, FIFO_LOG2 = 2.

1. **Streaming, ready = 1.** Push 32 samples 0..31 back-to-back -> fft_data_data = 0..31 sign-extended, each one cycle later; tlast on samples 7, 15, 23, 31; in_overflow = 0.
2. **Backpressure.** Hold ready = 0 and push 5 samples -> first 4 are held, 5th is dropped and in_overflow = 1 next cycle. Release ready -> 0..3 emerge in order, tlast not set.
3. **Linear collection** (TRANSPOSE = 0). Send 32 result beats with correct tlast -> beats 0–15 go to bank 0 at addr 0..15 and beats 16–31 to bank 1 at addr 0..15; fft_2ndR_config pulses once, with the last write; busy falls.
4. **Transposed collection** (TRANSPOSE = 1). Beat at row 1, col 5 -> addr = 0b10101 = 21 -> bank 1, bank_wraddr 5.
5. **Early tlast.** Assert fft_result_last on beat rcol = 3 -> last_err = 1; the next beat writes row 1, col 0 (addr 8).
6. **Mid-frame clear.** Assert frame_start mid-frame together with filbuf_wren (value 9) and a result beat -> FIFO holds only 9; no bank write that cycle; flags cleared; the next result beat writes addr 0. Repeat with s_axi_aresetn low mid-frame -> all outputs at reset values.
